// File: rtl/io_pkg.sv
// +--------------------------------------------------------------------+
// | io_pkg: shared widths, port map indices and hilo encodings          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package io_pkg;

  localparam int IO_PORT_W    = 2;
  localparam int IO_DATA_W    = 8;
  localparam int NUM_BUTTONS  = 4;
  localparam int NUM_SWITCHES = 10;

  localparam logic [IO_PORT_W-1:0] PORT_BTN  = 2'd0;
  localparam logic [IO_PORT_W-1:0] PORT_SWLO = 2'd1;
  localparam logic [IO_PORT_W-1:0] PORT_SWHI = 2'd2;
  localparam logic [IO_PORT_W-1:0] PORT_EVT  = 2'd3;

  localparam logic [1:0] HILO_BOTH  = 2'b00;
  localparam logic [1:0] HILO_LO    = 2'b01;
  localparam logic [1:0] HILO_HI    = 2'b10;
  localparam logic [1:0] HILO_BOTH2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// +--------------------------------------------------------------------+
// | debounce_bit: synchronizer + debounce for one active-low button;   |
// | press_o pulses on the edge the stable level goes released->pressed |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   btn_sync;
  logic                   accept;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Counter only advances below CNT_LAST, so it can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (btn_sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = btn_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = accept & stable_q;

endmodule

`default_nettype wire

// File: rtl/io_input_capture.sv
// +--------------------------------------------------------------------+
// | io_input_capture: debounced buttons, synced switches, sticky press |
// | events with clear-on-read and irq. Option: IO_IRQ_MASK_EN (mask)   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module io_input_capture
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [IO_PORT_W-1:0]    io_port,
  input  logic [1:0]              hilo_in,
  input  logic                    re_i,
`ifdef IO_IRQ_MASK_EN
  input  logic                    we_i,
  input  logic [IO_DATA_W-1:0]    wr_data,
`endif
  output logic [IO_DATA_W-1:0]    rd_data,
  output logic [NUM_BUTTONS-1:0]  ev_pending,
  output logic                    irq
);

  logic [NUM_BUTTONS-1:0]  btn_stable;
  logic [NUM_BUTTONS-1:0]  ev_set;
  logic [NUM_BUTTONS-1:0]  ev_q, ev_d;
  logic                    irq_q, irq_d;
  logic [NUM_BUTTONS-1:0]  irq_mask;
  logic [3:0]              evt_hi;
  logic [NUM_SWITCHES-1:0] sw_pipe_q [SYNC_STAGES];
  logic [NUM_SWITCHES-1:0] sw_sync;
  logic                    sw_unused;
  logic                    rd_clear;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (buttons[i]),
      .stable_o(btn_stable[i]),
      .press_o (ev_set[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sw_pipe_q[s] <= '0;
    end else begin
      sw_pipe_q[0] <= switches;
      for (int s = 1; s < SYNC_STAGES; s++) sw_pipe_q[s] <= sw_pipe_q[s-1];
    end
  end

  assign sw_sync   = sw_pipe_q[SYNC_STAGES-1];
  assign sw_unused = sw_sync[9];

`ifdef IO_IRQ_MASK_EN
  logic [NUM_BUTTONS-1:0] mask_q;
  logic [3:0]             wr_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else if (we_i && (io_port == PORT_EVT)) begin
      mask_q <= wr_data[3:0];
    end
  end

  assign wr_unused = wr_data[7:4];
  assign irq_mask  = mask_q;
  assign evt_hi    = mask_q;
`else
  assign irq_mask = 4'hF;
  assign evt_hi   = 4'h0;
`endif

  always_comb begin
    rd_data = '0;
    case (io_port)
      PORT_BTN:  rd_data = {4'b0, ~btn_stable};
      PORT_SWLO: if (hilo_in != HILO_HI) rd_data = {3'b0, sw_sync[4:0]};
      PORT_SWHI: if (hilo_in != HILO_LO) rd_data = {4'b0, sw_sync[8:5]};
      PORT_EVT:  rd_data = {evt_hi, ev_q};
      default:   rd_data = '0;
    endcase
  end

  // A new press ORs in after the read clear, so set wins on a collision.
  assign rd_clear = re_i && (io_port == PORT_EVT);

  always_comb begin
    ev_d  = (rd_clear ? (ev_q & ~rd_data[3:0]) : ev_q) | ev_set;
    irq_d = |(ev_d & irq_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      irq_q <= irq_d;
    end
  end

  assign ev_pending = ev_q;
  assign irq        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_input_capture.sv
// +--------------------------------------------------------------------+
// | tb_io_input_capture: directed bench, DEBOUNCE_CYCLES=4, SYNC=2     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_io_input_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic [9:0] switches;
  logic [1:0] io_port;
  logic [1:0] hilo_in;
  logic       re_i;
`ifdef IO_IRQ_MASK_EN
  logic       we_i;
  logic [7:0] wr_data;
`endif
  logic [7:0] rd_data;
  logic [3:0] ev_pending;
  logic       irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_input_capture #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .switches  (switches),
    .io_port   (io_port),
    .hilo_in   (hilo_in),
    .re_i      (re_i),
`ifdef IO_IRQ_MASK_EN
    .we_i      (we_i),
    .wr_data   (wr_data),
`endif
    .rd_data   (rd_data),
    .ev_pending(ev_pending),
    .irq       (irq)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; buttons = 4'b0000; switches = 10'h0; io_port = 2'd0;
    hilo_in = 2'b00; re_i = 1'b0;
`ifdef IO_IRQ_MASK_EN
    we_i = 1'b0; wr_data = 8'h00;
`endif
    tick(3);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_port0: got %h exp 00", rd_data); end
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL rst_ev: got %h exp 0", ev_pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq); end
    io_port = 2'd3; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_port3: got %h exp 00", rd_data); end
    io_port = 2'd0; buttons = 4'hF;
    tick(1);
    reset = 1'b1;
    tick(10);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rel_port0: got %h exp 00", rd_data); end
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL rst_rel_ev: got %h exp 0", ev_pending); end
  endtask

  task automatic test_debounce_latency();
    io_port = 2'd0;
    buttons[2] = 1'b0;
    tick(5);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL lat_early_port0: got %h exp 00", rd_data); end
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL lat_early_ev: got %h exp 0", ev_pending); end
    tick(1);
    checks++; if (rd_data !== 8'h04) begin errors++; $display("FAIL lat_port0: got %h exp 04", rd_data); end
    checks++; if (ev_pending !== 4'b0100) begin errors++; $display("FAIL lat_ev: got %b exp 0100", ev_pending); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lat_irq: got %b exp 1", irq); end
    tick(3);
    checks++; if (rd_data !== 8'h04) begin errors++; $display("FAIL lat_hold_port0: got %h exp 04", rd_data); end
    // three-cycle glitch on button 1
    buttons[1] = 1'b0;
    tick(3);
    buttons[1] = 1'b1;
    tick(10);
    checks++; if (rd_data[1] !== 1'b0) begin errors++; $display("FAIL glitch_port0_b1: got %b exp 0", rd_data[1]); end
    checks++; if (ev_pending !== 4'b0100) begin errors++; $display("FAIL glitch_ev: got %b exp 0100", ev_pending); end
    // release sets no event
    buttons[2] = 1'b1;
    tick(8);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL release_port0: got %h exp 00", rd_data); end
    checks++; if (ev_pending !== 4'b0100) begin errors++; $display("FAIL release_ev: got %b exp 0100", ev_pending); end
  endtask

  task automatic test_switch_halves();
    switches = 10'h3A5;
    tick(3);
    hilo_in = 2'b00; io_port = 2'd1; #1;
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL sw00_p1: got %h exp 05", rd_data); end
    io_port = 2'd2; #1;
    checks++; if (rd_data !== 8'h0D) begin errors++; $display("FAIL sw00_p2: got %h exp 0D", rd_data); end
    hilo_in = 2'b01; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL sw01_p2: got %h exp 00", rd_data); end
    io_port = 2'd1; #1;
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL sw01_p1: got %h exp 05", rd_data); end
    hilo_in = 2'b10; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL sw10_p1: got %h exp 00", rd_data); end
    io_port = 2'd2; #1;
    checks++; if (rd_data !== 8'h0D) begin errors++; $display("FAIL sw10_p2: got %h exp 0D", rd_data); end
    hilo_in = 2'b11; #1;
    checks++; if (rd_data !== 8'h0D) begin errors++; $display("FAIL sw11_p2: got %h exp 0D", rd_data); end
    hilo_in = 2'b00; io_port = 2'd0;
  endtask

  task automatic test_clear_on_read();
    buttons[0] = 1'b0;
    tick(8);
    checks++; if (ev_pending !== 4'b0101) begin errors++; $display("FAIL cor_setup_ev: got %b exp 0101", ev_pending); end
    io_port = 2'd0; re_i = 1'b1;
    tick(1);
    re_i = 1'b0;
    checks++; if (ev_pending !== 4'b0101) begin errors++; $display("FAIL cor_port0_ev: got %b exp 0101", ev_pending); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cor_port0_irq: got %b exp 1", irq); end
    io_port = 2'd3; re_i = 1'b1; #1;
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL cor_rd: got %h exp 05", rd_data); end
    tick(1);
    re_i = 1'b0;
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL cor_ev: got %b exp 0000", ev_pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cor_irq: got %b exp 0", irq); end
    buttons[0] = 1'b1;
    tick(8);
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL cor_rel_ev: got %b exp 0000", ev_pending); end
  endtask

  task automatic test_collision();
    buttons[0] = 1'b0; tick(8);
    buttons[0] = 1'b1; tick(8);
    buttons[0] = 1'b0;
    tick(5);
    io_port = 2'd3; re_i = 1'b1; #1;
    checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL coll_rd: got %h exp 01", rd_data); end
    tick(1);
    re_i = 1'b0;
    checks++; if (ev_pending !== 4'b0001) begin errors++; $display("FAIL coll_ev: got %b exp 0001", ev_pending); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq: got %b exp 1", irq); end
    io_port = 2'd0; #1;
    checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL coll_port0: got %h exp 01", rd_data); end
  endtask

  task automatic test_reset_mid();
    buttons[3] = 1'b0;
    tick(4);
    #2 reset = 1'b0;
    #1;
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL rmid_ev: got %b exp 0000", ev_pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq: got %b exp 0", irq); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rmid_port0: got %h exp 00", rd_data); end
    buttons = 4'hF;
    tick(2);
    reset = 1'b1;
    tick(10);
    checks++; if (ev_pending !== 4'h0) begin errors++; $display("FAIL rmid_after_ev: got %b exp 0000", ev_pending); end
  endtask

`ifdef IO_IRQ_MASK_EN
  task automatic test_irq_mask();
    buttons[1] = 1'b0; tick(8);
    checks++; if (ev_pending !== 4'b0010) begin errors++; $display("FAIL mask_ev: got %b exp 0010", ev_pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b exp 0", irq); end
    buttons[1] = 1'b1; tick(8);
    io_port = 2'd3; re_i = 1'b1; tick(1); re_i = 1'b0;
    we_i = 1'b1; wr_data = 8'h01; tick(1); we_i = 1'b0; wr_data = 8'h00;
    buttons[2] = 1'b0; tick(8);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_b2_irq: got %b exp 0", irq); end
    buttons[0] = 1'b0; tick(8);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_b0_irq: got %b exp 1", irq); end
    io_port = 2'd3; #1;
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL mask_rd: got %h exp 15", rd_data); end
    buttons = 4'hF; tick(8);
  endtask
`endif

  initial begin
    test_reset();
    test_debounce_latency();
    test_switch_halves();
    test_clear_on_read();
    test_collision();
    test_reset_mid();
`ifdef IO_IRQ_MASK_EN
    test_irq_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
